// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with valid/ready request and response channels.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply; divides stay iterative in both builds.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] input0,
    input  logic [DATA_WIDTH-1:0] input1,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  is_zero
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;

    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    logic [1:0]     state;
    logic [2:0]     op;
    logic           sign0;
    logic           sign1;
    logic [CW-1:0]  count;
    logic [2*W-1:0] acc;
    logic [W-1:0]   b_reg;
    logic           special;
    logic [W-1:0]   special_val;

    logic           signed0;
    logic           signed1;
    logic           neg0;
    logic           neg1;
    logic [W-1:0]   mag0;
    logic [W-1:0]   mag1;
    logic           div_zero;
    logic           div_ovf;
    logic [W-1:0]   special_now;
    logic           fast_now;
    logic [CW-1:0]  first_count;

    logic [W:0]     sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     rem_sh;
    logic [W:0]     diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] next_acc;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s;
    logic [W-1:0]   rem_s;
    logic [W-1:0]   result;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign is_zero    = (out == '0);

`ifdef MULDIV_FAST_MUL_EN
    assign fast_now = ~funct3[2];
`else
    assign fast_now = 1'b0;
`endif

    // Request decode: operand magnitudes, result signs and the divide corner cases.
    always_comb begin
        signed0 = 1'b0;
        signed1 = 1'b0;
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                signed0 = 1'b1;
                signed1 = 1'b1;
            end
            F3_MULHSU: signed0 = 1'b1;
            default: ;
        endcase
        neg0 = signed0 & input0[W-1];
        neg1 = signed1 & input1[W-1];
        mag0 = neg0 ? -input0 : input0;
        mag1 = neg1 ? -input1 : input1;
        div_zero = funct3[2] & (input1 == '0);
        div_ovf  = funct3[2] & ~funct3[0] & (input0 == MOST_NEG) & (input1 == '1);
        if (div_zero)
            special_now = funct3[1] ? input0 : '1;
        else
            special_now = funct3[1] ? '0 : input0;
        first_count = (div_zero | div_ovf | fast_now) ? '0 : LAST_STEP;
    end

    // acc is {high, low}: multiply shifts the product in from the top, divide shifts
    // quotient bits in at the bottom while the partial remainder grows in the top half.
    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + {1'b0, b_reg};
        mul_next = acc[0] ? {sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
        rem_sh   = {acc[2*W-1:W], acc[W-1]};
        diff     = rem_sh - {1'b0, b_reg};
        div_next = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                           : {diff[W-1:0], acc[W-2:0], 1'b1};
        next_acc = op[2] ? div_next : mul_next;
`ifdef MULDIV_FAST_MUL_EN
        prod = {{W{1'b0}}, b_reg} * {{W{1'b0}}, acc[W-1:0]};
`else
        prod = mul_next;
`endif
        prod_s = (sign0 ^ sign1) ? -prod : prod;
        quot_s = (sign0 ^ sign1) ? -div_next[W-1:0] : div_next[W-1:0];
        rem_s  = sign0 ? -div_next[2*W-1:W] : div_next[2*W-1:W];
        case (op)
            F3_MUL:                      result = prod_s[W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_s[2*W-1:W];
            F3_DIV, F3_DIVU:             result = quot_s;
            default:                     result = rem_s;
        endcase
        if (special)
            result = special_val;
    end

    // Corner cases and fast multiplies load a zero count, so they finish after one BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= F3_MUL;
            sign0       <= 1'b0;
            sign1       <= 1'b0;
            count       <= '0;
            acc         <= '0;
            b_reg       <= '0;
            special     <= 1'b0;
            special_val <= '0;
            out         <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op          <= funct3;
                        sign0       <= neg0;
                        sign1       <= neg1;
                        count       <= first_count;
                        acc         <= {{W{1'b0}}, (funct3[2] ? mag0 : mag1)};
                        b_reg       <= funct3[2] ? mag1 : mag0;
                        special     <= div_zero | div_ovf;
                        special_val <= special_now;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= next_acc;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        out   <= result;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; multiply latency follows MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W;
`endif
    localparam int DIV_LAT = W;
    localparam int SPC_LAT = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   funct3 = 3'b000;
    logic [W-1:0] input0 = '0;
    logic [W-1:0] input1 = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] out;
    logic         is_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct3    (funct3),
        .input0    (input0),
        .input1    (input1),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .out       (out),
        .is_zero   (is_zero)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One full transaction: request, latency count, result, optional backpressure, handshake.
    task automatic applyStimulus(input string tag, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] expv, input int exp_lat, input int hold);
        int   lat = -1;
        logic stable = 1'b1;
        @(negedge clk);
        checkOutput({tag, " req_ready idle"}, W'(req_ready), W'(1));
        req_valid = 1'b1;
        funct3    = op;
        input0    = a;
        input1    = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        funct3    = 3'($urandom);
        input0    = $urandom;
        input1    = $urandom;
        if (resp_valid) begin
            lat = 0;
        end else begin
            for (int n = 1; n <= 2 * W + 8; n++) begin
                @(posedge clk);
                #1;
                if (resp_valid) begin
                    lat = n;
                    break;
                end
            end
        end
        checkOutput({tag, " latency"}, W'(lat), W'(exp_lat));
        checkOutput({tag, " out"}, out, expv);
        checkOutput({tag, " is_zero"}, W'(is_zero), W'(expv == '0));
        checkOutput({tag, " req_ready busy"}, W'(req_ready), W'(0));
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (out !== expv || resp_valid !== 1'b1 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0)
            checkOutput({tag, " held stable"}, W'(stable), W'(1));
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        funct3     = 3'b101;
        input0     = 32'd9;
        input1     = 32'd3;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        checkOutput({tag, " resp_valid after hs"}, W'(resp_valid), W'(0));
        checkOutput({tag, " req_ready after hs"}, W'(req_ready), W'(1));
    endtask

    initial begin
        int seen = 0;
        #3;
        checkOutput("reset req_ready", W'(req_ready), W'(1));
        checkOutput("reset resp_valid", W'(resp_valid), W'(0));
        checkOutput("reset out", out, 32'h0);
        checkOutput("reset is_zero", W'(is_zero), W'(1));
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("MUL 7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
        applyStimulus("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
        applyStimulus("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
        applyStimulus("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, 0);

        applyStimulus("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 0);
        applyStimulus("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT, 0);
        applyStimulus("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 0);
        applyStimulus("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, 0);
        applyStimulus("DIV 6/6", 3'b100, 32'd6, 32'd6, 32'd1, DIV_LAT, 0);
        applyStimulus("REM 6/6", 3'b110, 32'd6, 32'd6, 32'd0, DIV_LAT, 0);

        applyStimulus("DIV x/0", 3'b100, 32'd55, 32'd0, 32'hFFFF_FFFF, SPC_LAT, 0);
        applyStimulus("REMU x/0", 3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234, SPC_LAT, 0);
        applyStimulus("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, 0);
        applyStimulus("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPC_LAT, 0);

        applyStimulus("backpressure MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFE, MUL_LAT, 10);
        applyStimulus("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, DIV_LAT, 0);

        @(negedge clk);
        req_valid = 1'b1;
        funct3    = 3'b101;
        input0    = 32'd1000;
        input1    = 32'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("flush busy before", W'(req_ready), W'(0));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush req_ready", W'(req_ready), W'(1));
        checkOutput("flush resp_valid", W'(resp_valid), W'(0));
        repeat (2 * W) begin
            @(posedge clk);
            #1;
            if (resp_valid)
                seen++;
        end
        checkOutput("flush no response", W'(seen), W'(0));

        @(negedge clk);
        req_valid = 1'b1;
        funct3    = 3'b000;
        input0    = 32'h0000_1234;
        input1    = 32'h0000_0010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid resp_valid", W'(resp_valid), W'(0));
        checkOutput("reset mid out", out, 32'h0);
        checkOutput("reset mid is_zero", W'(is_zero), W'(1));
        checkOutput("reset mid req_ready", W'(req_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("MUL 3x5", 3'b000, 32'd3, 32'd5, 32'd15, MUL_LAT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
